// File: rtl/accumulator_correction_mt.sv
// Correction accumulator: pseudo-accumulates matched weights as if every timestep
// spiked, then subtracts per-timestep corrections fetched from Fibre A spike words.
module accumulator_correction_mt #(
  parameter int TIMESTEPS    = 4,
  parameter int WEIGHT_WIDTH = 8,
  parameter int ADDR_WIDTH   = 8,
  parameter int ACC_WIDTH    = 16,
  parameter int OUT_WIDTH    = 12,
  parameter int FIFO_DEPTH   = 8,
  parameter bit SATURATE     = 1'b1
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           in_valid,
  output logic                           in_ready,
  input  logic signed [WEIGHT_WIDTH-1:0] in_weight,
  input  logic [ADDR_WIDTH-1:0]          in_offset,
  input  logic                           in_last,
  output logic [ADDR_WIDTH-1:0]          mem_addr,
  output logic                           mem_rd_en,
  input  logic [TIMESTEPS-1:0]           mem_rdata,
  input  logic                           mem_rvalid,
  output logic                           out_valid,
  input  logic                           out_ready,
  output logic [TIMESTEPS*OUT_WIDTH-1:0] out_data,
  output logic [TIMESTEPS-1:0]           out_overflow,
  output logic                           busy,
  output logic [1:0]                     dbg_state
);
  // Handshakes: a transfer happens on a clk edge where valid && ready; valid, once
  // raised by the producer, holds its payload stable until that edge.
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam logic signed [ACC_WIDTH-1:0] OUT_MAX = ACC_WIDTH'((1 << (OUT_WIDTH-1)) - 1);
  localparam logic signed [ACC_WIDTH-1:0] OUT_MIN = -OUT_MAX - ACC_WIDTH'(1);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_FINAL, S_OUTPUT} state_t;
  state_t state, state_nx;

  logic [WEIGHT_WIDTH-1:0] fifo_w [FIFO_DEPTH];
  logic [ADDR_WIDTH-1:0]   fifo_o [FIFO_DEPTH];
  logic                    fifo_l [FIFO_DEPTH];
  logic [PTR_W-1:0]        wr_ptr, rd_ptr;
  logic [PTR_W:0]          count;
  logic fifo_full, fifo_empty, fibre_closed;
  logic push, pop, out_fire;

  logic signed [ACC_WIDTH-1:0]    pseudo_acc;
  logic signed [ACC_WIDTH-1:0]    corr [TIMESTEPS];
  logic signed [WEIGHT_WIDTH-1:0] cur_weight;
  logic                           cur_last;
  logic [TIMESTEPS*OUT_WIDTH-1:0] lanes;
  logic [TIMESTEPS-1:0]           ovf;

  function automatic logic signed [ACC_WIDTH-1:0] sext(input logic [WEIGHT_WIDTH-1:0] w);
    return {{(ACC_WIDTH-WEIGHT_WIDTH){w[WEIGHT_WIDTH-1]}}, w};
  endfunction

  assign fifo_full  = (count == (PTR_W+1)'(FIFO_DEPTH));
  assign fifo_empty = (count == '0);
  assign in_ready   = rst_n && !fifo_full && !fibre_closed;
  assign push       = in_valid && in_ready;
  assign pop        = (state == S_IDLE) && !fifo_empty;
  assign out_fire   = (state == S_OUTPUT) && out_ready;
  assign busy       = !fifo_empty || (state != S_IDLE);
  assign dbg_state  = state;

  always_ff @(posedge clk) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE:   if (!fifo_empty) state_nx = S_WAIT;
      S_WAIT:   if (mem_rvalid) state_nx = cur_last ? S_FINAL : S_IDLE;
      S_FINAL:  state_nx = S_OUTPUT;
      S_OUTPUT: if (out_ready) state_nx = S_IDLE;
      default:  state_nx = S_IDLE;
    endcase
  end

  // Lane result is the sum of weights whose timestep spiked, reached as pseudo - corr.
  always_comb begin
    logic signed [ACC_WIDTH-1:0] r;
    r     = '0;
    lanes = '0;
    ovf   = '0;
    for (int t = 0; t < TIMESTEPS; t++) begin
      r      = pseudo_acc - corr[t];
      ovf[t] = (r > OUT_MAX) || (r < OUT_MIN);
      if (SATURATE && (r > OUT_MAX))      lanes[t*OUT_WIDTH +: OUT_WIDTH] = OUT_MAX[OUT_WIDTH-1:0];
      else if (SATURATE && (r < OUT_MIN)) lanes[t*OUT_WIDTH +: OUT_WIDTH] = OUT_MIN[OUT_WIDTH-1:0];
      else                                lanes[t*OUT_WIDTH +: OUT_WIDTH] = r[OUT_WIDTH-1:0];
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      fifo_w[wr_ptr] <= in_weight;
      fifo_o[wr_ptr] <= in_offset;
      fifo_l[wr_ptr] <= in_last;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      count        <= '0;
      fibre_closed <= 1'b0;
      pseudo_acc   <= '0;
      for (int t = 0; t < TIMESTEPS; t++) corr[t] <= '0;
      cur_weight   <= '0;
      cur_last     <= 1'b0;
      mem_addr     <= '0;
      mem_rd_en    <= 1'b0;
      out_valid    <= 1'b0;
      out_data     <= '0;
      out_overflow <= '0;
    end else begin
      mem_rd_en <= 1'b0;
      if (push) begin
        wr_ptr     <= wr_ptr + PTR_W'(1);
        pseudo_acc <= pseudo_acc + sext(in_weight);
        if (in_last) fibre_closed <= 1'b1;
      end
      if (pop) begin
        rd_ptr     <= rd_ptr + PTR_W'(1);
        cur_weight <= fifo_w[rd_ptr];
        cur_last   <= fifo_l[rd_ptr];
        mem_addr   <= fifo_o[rd_ptr];
        mem_rd_en  <= 1'b1;
      end
      if (push && !pop)      count <= count + (PTR_W+1)'(1);
      else if (pop && !push) count <= count - (PTR_W+1)'(1);
      if ((state == S_WAIT) && mem_rvalid) begin
        for (int t = 0; t < TIMESTEPS; t++)
          if (!mem_rdata[t]) corr[t] <= corr[t] + sext(cur_weight);
      end
      if (state == S_FINAL) begin
        out_data     <= lanes;
        out_overflow <= ovf;
        out_valid    <= 1'b1;
      end
      // fibre_closed blocks accepts until here, so this clear never races a push.
      if (out_fire) begin
        out_valid    <= 1'b0;
        pseudo_acc   <= '0;
        fibre_closed <= 1'b0;
        for (int t = 0; t < TIMESTEPS; t++) corr[t] <= '0;
      end
    end
  end
endmodule

// File: tb/tb_accumulator_correction_mt.sv
// Bench for accumulator_correction_mt: a saturating and a truncating instance share
// stimulus; results are predicted as per-lane sums of weights whose timestep spiked.
module tb_accumulator_correction_mt;
  localparam int TS = 4, WW = 8, AW = 8, ACCW = 16, OW = 8, FD = 8;
  localparam int EW = 2*TS*OW + TS;
  localparam int LMAX = (1 << (OW-1)) - 1;
  localparam int LMIN = -(1 << (OW-1));

  logic clk = 1'b0, rst_n = 1'b0;
  logic in_valid = 1'b0, in_last = 1'b0, out_ready = 1'b1, mem_rvalid = 1'b0;
  logic signed [WW-1:0] in_weight = '0;
  logic [AW-1:0] in_offset = '0;
  logic [TS-1:0] mem_rdata = '0;

  logic in_ready_s, in_ready_t, mem_rd_en_s, mem_rd_en_t, out_valid_s, out_valid_t, busy_s, busy_t;
  logic [AW-1:0] mem_addr_s, mem_addr_t;
  logic [TS*OW-1:0] out_data_s, out_data_t;
  logic [TS-1:0] out_ovf_s, out_ovf_t;
  logic [1:0] dbg_s, dbg_t;

  accumulator_correction_mt #(.TIMESTEPS(TS), .WEIGHT_WIDTH(WW), .ADDR_WIDTH(AW), .ACC_WIDTH(ACCW),
    .OUT_WIDTH(OW), .FIFO_DEPTH(FD), .SATURATE(1'b1)) dut_s (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_s), .in_weight(in_weight),
    .in_offset(in_offset), .in_last(in_last), .mem_addr(mem_addr_s), .mem_rd_en(mem_rd_en_s),
    .mem_rdata(mem_rdata), .mem_rvalid(mem_rvalid), .out_valid(out_valid_s), .out_ready(out_ready),
    .out_data(out_data_s), .out_overflow(out_ovf_s), .busy(busy_s), .dbg_state(dbg_s));

  accumulator_correction_mt #(.TIMESTEPS(TS), .WEIGHT_WIDTH(WW), .ADDR_WIDTH(AW), .ACC_WIDTH(ACCW),
    .OUT_WIDTH(OW), .FIFO_DEPTH(FD), .SATURATE(1'b0)) dut_t (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_t), .in_weight(in_weight),
    .in_offset(in_offset), .in_last(in_last), .mem_addr(mem_addr_t), .mem_rd_en(mem_rd_en_t),
    .mem_rdata(mem_rdata), .mem_rvalid(mem_rvalid), .out_valid(out_valid_t), .out_ready(out_ready),
    .out_data(out_data_t), .out_overflow(out_ovf_t), .busy(busy_t), .dbg_state(dbg_t));

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard state ----------------
  int checks = 0, passes = 0;
  logic [EW-1:0] exp_q[$];
  int fib_sum[TS];
  logic [TS-1:0] mem [256];
  int lat = 1;
  bit stall = 1'b0;
  bit rand_rdy = 1'b0;
  int rd_cnt = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic add_entry(input int w, input logic [AW-1:0] off);
    for (int t = 0; t < TS; t++)
      if (mem[off][t]) fib_sum[t] += w;
  endtask

  // Expected lanes: the spiked-weight sum, wrapped to the accumulator width, then clamped or truncated.
  task automatic close_fibre();
    logic [TS*OW-1:0] sat, tr;
    logic [TS-1:0] ov;
    logic signed [ACCW-1:0] r;
    int ri, si;
    for (int t = 0; t < TS; t++) begin
      r = ACCW'(fib_sum[t]);
      ri = r;
      ov[t] = (ri > LMAX) || (ri < LMIN);
      si = (ri > LMAX) ? LMAX : ((ri < LMIN) ? LMIN : ri);
      sat[t*OW +: OW] = OW'(si);
      tr[t*OW +: OW] = r[OW-1:0];
      fib_sum[t] = 0;
    end
    exp_q.push_back({sat, tr, ov});
  endtask

  // ---------------- memory responder ----------------
  initial begin
    logic [AW-1:0] a;
    forever begin
      @(posedge clk);
      if (mem_rd_en_s) begin
        a = mem_addr_s;
        while (stall) @(posedge clk);
        repeat (lat - 1) @(posedge clk);
        #1; mem_rvalid = 1'b1; mem_rdata = mem[a];
        @(posedge clk);
        #1; mem_rvalid = 1'b0; mem_rdata = '0;
      end
    end
  end

  always @(negedge clk) if (mem_rd_en_s) rd_cnt++;

  always @(posedge clk) if (rand_rdy) begin
    #1; out_ready = 1'($urandom_range(0, 1));
  end

  // ---------------- monitor ----------------
  logic [EW-1:0] e;
  always @(negedge clk) begin
    if (rst_n && out_valid_s && out_ready) begin
      if (exp_q.size() == 0) chk("unexpected_output", out_valid_s, 0);
      else begin
        e = exp_q.pop_front();
        chk("lanes_sat", out_data_s, e[EW-1 -: TS*OW]);
        chk("lanes_trunc", out_data_t, e[TS*OW+TS-1 -: TS*OW]);
        chk("ovf_sat", out_ovf_s, e[TS-1:0]);
        chk("ovf_trunc", out_ovf_t, e[TS-1:0]);
        chk("valid_trunc", out_valid_t, 1);
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic send(input int w, input logic [AW-1:0] off, input logic last);
    int n = 0;
    in_valid = 1'b1; in_weight = WW'(w); in_offset = off; in_last = last;
    while (!in_ready_s && n < 3000) begin @(posedge clk); #1; n++; end
    if (!in_ready_s) chk("accept_timeout", in_ready_s, 1);
    add_entry(w, off);
    @(posedge clk); #1;
    in_valid = 1'b0; in_last = 1'b0;
    if (last) close_fibre();
  endtask

  task automatic drain();
    int n = 0;
    while ((exp_q.size() != 0 || busy_s) && n < 3000) begin @(posedge clk); #1; n++; end
    chk("drain_queue", exp_q.size(), 0);
    chk("drain_idle", busy_s, 0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int k, n, rd0, len;
    bit stable, rdy_low;
    logic [TS*OW-1:0] held;
    int fw[16];
    logic [AW-1:0] fo[16];

    for (int a = 0; a < 256; a++) mem[a] = TS'($urandom);
    mem[240] = 4'b1111; mem[241] = 4'b0101; mem[242] = 4'b1010;
    mem[243] = 4'b0000; mem[244] = 4'b0001; mem[245] = 4'b0011;
    for (int t = 0; t < TS; t++) fib_sum[t] = 0;

    repeat (3) @(posedge clk);
    #1;
    chk("rst_in_ready", in_ready_s, 0);
    chk("rst_rd_en", mem_rd_en_s, 0);
    chk("rst_addr", mem_addr_s, 0);
    chk("rst_out_valid", out_valid_s, 0);
    chk("rst_out_data", out_data_s, 0);
    chk("rst_ovf", out_ovf_s, 0);
    chk("rst_busy", busy_s, 0);
    rst_n = 1'b1;
    #1;
    chk("post_rst_in_ready", in_ready_s, 1);

    // three-entry fibre: lanes 8,7,8,7
    lat = 1;
    send(5, 240, 0); send(3, 241, 0); send(2, 242, 1);
    drain();
    // negative weight with empty spike word: all lanes 6
    send(-4, 243, 0); send(6, 240, 1);
    drain();
    // 20 x 127 all-spiked: clamps to 127 / wraps to -20, overflow on every lane
    lat = 2;
    for (int i = 0; i < 20; i++) send(127, 240, i == 19);
    drain();

    // FIFO fill with reads stalled
    stall = 1'b1;
    rd0 = rd_cnt;
    for (int i = 0; i < 16; i++) begin
      fw[i] = int'($urandom_range(0, 255)) - 128;
      fo[i] = AW'($urandom_range(0, 239));
    end
    k = 0;
    in_valid = 1'b1; in_last = 1'b0; in_weight = WW'(fw[0]); in_offset = fo[0];
    repeat (20) begin
      if (in_ready_s) begin add_entry(fw[k], fo[k]); k++; end
      @(posedge clk); #1;
      in_weight = WW'(fw[k]); in_offset = fo[k];
    end
    in_valid = 1'b0;
    chk("fifo_accepts", k, FD + 1);
    chk("fifo_in_ready_low", in_ready_s, 0);
    chk("fifo_rd_pulses", rd_cnt - rd0, 1);
    lat = 3;
    stall = 1'b0;
    send(int'($urandom_range(0, 255)) - 128, AW'($urandom_range(0, 239)), 1);
    drain();

    // output backpressure
    out_ready = 1'b0;
    send(7, 245, 1);
    n = 0;
    while (!out_valid_s && n < 200) begin @(posedge clk); #1; n++; end
    chk("hold_valid_seen", out_valid_s, 1);
    held = out_data_s; stable = 1'b1; rdy_low = 1'b1;
    repeat (10) begin
      @(posedge clk); #1;
      if (out_data_s !== held || !out_valid_s) stable = 1'b0;
      if (in_ready_s) rdy_low = 1'b0;
    end
    chk("hold_stable", stable, 1);
    chk("hold_in_ready_low", rdy_low, 1);
    out_ready = 1'b1;
    drain();
    send(1, 244, 1);
    drain();

    // reset while waiting on a read
    lat = 2;
    stall = 1'b1;
    rd0 = rd_cnt;
    send(9, 241, 0);
    n = 0;
    while (rd_cnt == rd0 && n < 200) begin @(posedge clk); #1; n++; end
    chk("rst_mid_read_issued", rd_cnt - rd0, 1);
    rst_n = 1'b0;
    @(posedge clk); #1;
    chk("rst_mid_in_ready", in_ready_s, 0);
    chk("rst_mid_busy", busy_s, 0);
    chk("rst_mid_out_valid", out_valid_s, 0);
    for (int t = 0; t < TS; t++) fib_sum[t] = 0;
    rst_n = 1'b1;
    stall = 1'b0;
    repeat (8) @(posedge clk);
    #1;
    chk("post_rst_busy", busy_s, 0);
    chk("post_rst_out_valid", out_valid_s, 0);
    chk("post_rst_state", dbg_s, 0);
    send(2, 242, 0); send(3, 245, 1);
    drain();

    // randomized fibres with random read latency and output backpressure
    rand_rdy = 1'b1;
    for (int f = 0; f < 12; f++) begin
      len = $urandom_range(1, 6);
      lat = $urandom_range(1, 4);
      for (int i = 0; i < len; i++) begin
        repeat ($urandom_range(0, 2)) @(posedge clk);
        #1;
        send(int'($urandom_range(0, 255)) - 128, AW'($urandom_range(0, 255)), i == len - 1);
      end
    end
    drain();
    rand_rdy = 1'b0;
    @(posedge clk); #2;
    out_ready = 1'b1;

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule

// File: doc/accumulator_correction_mt.md
Name: accumulator_correction_mt

Overview:
- Parametrised successor of the single-entry correction accumulator in the LoAS datapath.
- Consumes the matched-weight stream from the prefix-match stage and pseudo-accumulates every weight as if all timesteps spiked.
- Fetches each entry's TIMESTEPS-bit spike word from Fibre A memory and accumulates a per-timestep correction.
- At fibre end, emits TIMESTEPS signed, optionally saturated sums with valid/ready backpressure. An internal FIFO lets the correction path lag the match stream.

Parameters:
TIMESTEPS, 4, timesteps per spike word and number of output lanes
WEIGHT_WIDTH, 8, signed weight width
ADDR_WIDTH, 8, Fibre A address width
ACC_WIDTH, 16, signed width of the pseudo and correction accumulators
OUT_WIDTH, 12, signed width of each output lane
FIFO_DEPTH, 8, pending-correction FIFO entries (power of 2, >=2)
SATURATE, 1, 1 = clamp outputs to the OUT_WIDTH range; 0 = truncate

Ports:
clk  in  1  clock
rst_n  in  1  reset (see interface)
in_valid  in  1  matched entry valid
in_ready  out  1  entry accepted when in_valid && in_ready
in_weight  in  WEIGHT_WIDTH  signed matched weight
in_offset  in  ADDR_WIDTH  Fibre A address of the entry's spike word
in_last  in  1  entry is the final one of the current fibre
mem_addr  out  ADDR_WIDTH  Fibre A read address
mem_rd_en  out  1  one-cycle read strobe
mem_rdata  in  TIMESTEPS  spike word; bit t = timestep t
mem_rvalid  in  1  mem_rdata valid, arbitrary latency >=1 after mem_rd_en
out_valid  out  1  results valid
out_ready  in  1  downstream accepts
out_data  out  TIMESTEPS*OUT_WIDTH  lane t at bits [t*OUT_WIDTH +: OUT_WIDTH]
out_overflow  out  TIMESTEPS  lane t exceeded the OUT_WIDTH range
busy  out  1  FIFO non-empty or FSM not in IDLE

Behaviour:
Interface:
- One clock, clk.
- Reset rst_n is synchronous and active-low.

Reset:
- While rst_n is low at a clk edge, all registers clear: both accumulators, FIFO pointers and count, and the fibre_closed flag.
- Outputs after reset: mem_rd_en=0, mem_addr=0, out_valid=0, out_data=0, out_overflow=0, busy=0.
- in_ready reads 0 while rst_n is low.
- Reset mid-operation abandons all work. Any mem_rvalid arriving afterwards is ignored.

Input side:
- in_ready = !fifo_full && !fibre_closed.
- On accept: pseudo_acc += sign_extend(in_weight) (wraps mod 2^ACC_WIDTH). {weight, offset, last} is pushed to the FIFO. If in_last, fibre_closed is set.
- A push and a pop in the same cycle are legal; the count is unchanged.

Correction FSM:
- IDLE: if the FIFO is non-empty, pop, latch the entry, drive mem_addr=offset and mem_rd_en=1 for exactly one cycle, go WAIT. mem_rvalid is ignored in IDLE.
- WAIT: on mem_rvalid, for each t with mem_rdata[t]==0, corr[t] += weight (signed, all lanes in the same cycle). Next state is FINAL if the latched last is set, else IDLE. An all-ones spike word adds nothing and takes the same path.
- FINAL: for each lane, res[t] = pseudo_acc - corr[t] at ACC_WIDTH.
  - If res[t] is outside [-2^(OUT_WIDTH-1), 2^(OUT_WIDTH-1)-1], out_overflow[t]=1.
  - The lane is clamped if SATURATE=1, else the low OUT_WIDTH bits are taken.
  - Register out_data and out_overflow, set out_valid, go OUTPUT.
- OUTPUT: out_valid, out_data and out_overflow are held stable until out_ready.
  - On handshake: out_valid=0; pseudo_acc, all corr[t] and fibre_closed clear the same edge; go IDLE.

Latency and ordering:
- Minimum from the last entry's mem_rvalid to out_valid is 2 cycles: WAIT→FINAL, then FINAL registers.
- Next-fibre entries are not accepted until the output handshake completes, so fibres never mix.
- With reads stalled, FIFO_DEPTH entries are queued plus one in flight, so FIFO_DEPTH+1 entries are accepted before in_ready falls.

Test Plan:
- TIMESTEPS=4. Weights 5, 3, 2 with spike words 1111, 0101, 1010; last on the third entry → out lanes t0..t3 = 8, 7, 8, 7; overflow=0000.
- Weights -4 (spike 0000), then 6 (spike 1111, last) → pseudo 2, corr = -4 on all lanes → all lanes 6.
- OUT_WIDTH=8, SATURATE=1: 20 entries of weight 127, spike 1111, last on the 20th → all lanes 127, overflow=1111. With SATURATE=0: all lanes 2540 mod 256 = -20, overflow=1111.
- FIFO_DEPTH=8, mem_rvalid held low, in_valid held high → exactly 9 accepts, then in_ready=0, exactly one mem_rd_en pulse. Release with 3-cycle read latency → all 9 corrections applied in order; result matches the reference model.
- out_ready held low 10 cycles after out_valid → out_data stable, in_ready=0. After handshake, next fibre (weight 1, spike 0001, last) → lanes 1, 0, 0, 0.
- rst_n low one cycle while in WAIT, then mem_rvalid pulses → no accumulation; outputs and busy at 0. A fresh fibre produces results unaffected by pre-reset data.
